// File: rtl/xgmii_enc_tx.sv
// 64b/66b transmit encoder: classifies each XGMII vector, runs the clause 49/82
// transmit state machine and emits one registered 66-bit block per accepted vector.
module xgmii_enc_tx #(
  parameter int IS_40G       = 1,
  parameter int HEAD_W       = 2,
  parameter int DATA_W       = 64,
  parameter int XGMII_CTRL_W = 8
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    valid_i,
  input  logic [DATA_W-1:0]       xgmii_txd_i,
  input  logic [XGMII_CTRL_W-1:0] xgmii_txc_i,
  output logic                    valid_o,
  output logic [HEAD_W-1:0]       head_o,
  output logic [DATA_W-1:0]       data_o
);

  localparam int LANES = XGMII_CTRL_W;
  localparam int K_W   = $clog2(XGMII_CTRL_W);
  localparam logic [HEAD_W-1:0] HDR_DATA = HEAD_W'(2'b01);
  localparam logic [HEAD_W-1:0] HDR_CTRL = HEAD_W'(2'b10);
  localparam logic [DATA_W-1:0] ERR_BLK  = {{LANES{7'h1e}}, 8'h1e};
  // Terminate block types, indexed by the lane holding /T/.
  localparam logic [63:0] T_TYPES = {8'hff, 8'he1, 8'hd2, 8'hcc, 8'hb4, 8'haa, 8'h99, 8'h87};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} state_e;
  typedef enum logic [2:0] {CL_C, CL_S, CL_T, CL_D, CL_E} cls_e;

  state_e state_q, state_d;
  cls_e   cls;

  logic              valid_q;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [LANES-1:0]   lane_idle, lane_err, t_hit;
  logic [7*LANES-1:0] c_codes;
  logic               is_c, is_s0, is_s4, is_t, is_d;
  logic [K_W-1:0]     t_k;
  logic [DATA_W-1:0]  t_blk;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // A /T/ in lane gi needs data below it and idles above it.
      localparam logic [LANES-1:0] LOW_M  = LANES'((1 << gi) - 1);
      localparam logic [LANES-1:0] HIGH_M = ~(LOW_M | LANES'(1 << gi));
      logic [7:0] lane;
      assign lane           = xgmii_txd_i[8*gi +: 8];
      assign lane_idle[gi]  = xgmii_txc_i[gi] && (lane == 8'h07);
      assign lane_err[gi]   = xgmii_txc_i[gi] && (lane == 8'hfe);
      assign c_codes[7*gi +: 7] = lane_err[gi] ? 7'h1e : 7'h00;
      assign t_hit[gi] = xgmii_txc_i[gi] && (lane == 8'hfd)
                         && ((xgmii_txc_i & LOW_M) == '0)
                         && ((lane_idle & HIGH_M) == HIGH_M);
    end
  endgenerate

  assign is_c  = &(lane_idle | lane_err);
  assign is_s0 = (xgmii_txc_i == 8'h01) && (xgmii_txd_i[7:0] == 8'hfb);
  assign is_s4 = (IS_40G == 0) && (xgmii_txc_i == 8'h1f)
                 && (xgmii_txd_i[39:32] == 8'hfb) && (&lane_idle[3:0]);
  assign is_t  = |t_hit;
  assign is_d  = (xgmii_txc_i == '0);

  always_comb begin
    t_k = '0;
    for (int k = 0; k < LANES; k++)
      if (t_hit[k]) t_k = K_W'(k);
  end

  always_comb begin
    if (is_c)               cls = CL_C;
    else if (is_s0 || is_s4) cls = CL_S;
    else if (is_t)          cls = CL_T;
    else if (is_d)          cls = CL_D;
    else                    cls = CL_E;
  end

  always_comb begin
    t_blk = '0;
    t_blk[7:0] = T_TYPES[8*t_k +: 8];
    for (int j = 0; j < LANES - 1; j++)
      if (j < int'(t_k)) t_blk[8 + 8*j +: 8] = xgmii_txd_i[8*j +: 8];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= TX_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (valid_i) begin
      case (state_q)
        TX_D: state_d = (cls == CL_D) ? TX_D : (cls == CL_T) ? TX_T : TX_E;
        TX_E: begin
          case (cls)
            CL_C:    state_d = TX_C;
            CL_D:    state_d = TX_D;
            CL_T:    state_d = TX_T;
            default: state_d = TX_E;
          endcase
        end
        default: state_d = (cls == CL_C) ? TX_C : (cls == CL_S) ? TX_D : TX_E;
      endcase
    end
  end

  always_comb begin
    head_d = HDR_CTRL;
    data_d = ERR_BLK;
    if (state_d != TX_E) begin
      case (cls)
        CL_D: begin
          head_d = HDR_DATA;
          data_d = xgmii_txd_i;
        end
        CL_C:    data_d = {c_codes, 8'h1e};
        CL_S:    data_d = is_s0 ? {xgmii_txd_i[63:8], 8'h78}
                                : {xgmii_txd_i[63:40], 32'h0, 8'h33};
        CL_T:    data_d = t_blk;
        default: data_d = ERR_BLK;
      endcase
    end
  end

  // A stalled cycle freezes the block but never re-announces it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      head_q  <= HDR_CTRL;
      data_q  <= ERR_BLK;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        head_q <= head_d;
        data_q <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_xgmii_enc_tx.sv
// Randomized bench for xgmii_enc_tx: drives an XLGMII and an XGMII instance in
// parallel and compares both against a byte-level reference model.
module tb_xgmii_enc_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        valid_i = 1'b0;
  logic [63:0] txd = '0;
  logic [7:0]  txc = '0;

  logic        vo40, vo10;
  logic [1:0]  ho40, ho10;
  logic [63:0] do40, do10;

  always #5 clk = ~clk;

  xgmii_enc_tx #(.IS_40G(1)) dut40 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i),
    .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .valid_o(vo40), .head_o(ho40), .data_o(do40)
  );

  xgmii_enc_tx #(.IS_40G(0)) dut10 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i),
    .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .valid_o(vo10), .head_o(ho10), .data_o(do10)
  );

  int checks_total = 0;
  int checks_passed = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  localparam int K_C = 0, K_S0 = 1, K_S4 = 2, K_T = 3, K_D = 4, K_E = 5;
  localparam int ST_INIT = 0, ST_C = 1, ST_D = 2, ST_T = 3, ST_E = 4;

  int          mstate [2];
  logic        mvalid [2];
  logic [1:0]  mhead  [2];
  logic [63:0] mdata  [2];

  function automatic logic [63:0] ctrl_block(logic [7:0] errmask);
    logic [63:0] acc;
    acc = '0;
    for (int i = 7; i >= 0; i--) acc = (acc << 7) | (errmask[i] ? 64'h1e : 64'h0);
    return (acc << 8) | 64'h1e;
  endfunction

  function automatic int classify(logic [63:0] d, logic [7:0] c, bit is40,
                                  output int tk, output logic [7:0] em);
    logic [7:0] b [8];
    int first_ctrl;
    bit all_ic, hi_idle;
    tk = 0;
    em = '0;
    all_ic = 1'b1;
    first_ctrl = 8;
    for (int i = 0; i < 8; i++) begin
      b[i] = d[8*i +: 8];
      em[i] = (b[i] == 8'hfe);
      if (!c[i] || !(b[i] == 8'h07 || b[i] == 8'hfe)) all_ic = 1'b0;
    end
    if (all_ic) return K_C;
    if (c == 8'h01 && b[0] == 8'hfb) return K_S0;
    if (!is40 && c == 8'h1f && b[4] == 8'hfb && b[0] == 8'h07 && b[1] == 8'h07
        && b[2] == 8'h07 && b[3] == 8'h07) return K_S4;
    for (int i = 7; i >= 0; i--) if (c[i]) first_ctrl = i;
    if (first_ctrl < 8 && b[first_ctrl] == 8'hfd) begin
      hi_idle = 1'b1;
      for (int i = first_ctrl + 1; i < 8; i++)
        if (!c[i] || b[i] != 8'h07) hi_idle = 1'b0;
      if (hi_idle) begin
        tk = first_ctrl;
        return K_T;
      end
    end
    if (c == 8'h00) return K_D;
    return K_E;
  endfunction

  function automatic int next_state(int st, int kind);
    bit is_s;
    is_s = (kind == K_S0) || (kind == K_S4);
    case (st)
      ST_D:    return (kind == K_D) ? ST_D : (kind == K_T) ? ST_T : ST_E;
      ST_E:    return (kind == K_C) ? ST_C : (kind == K_D) ? ST_D : (kind == K_T) ? ST_T : ST_E;
      default: return (kind == K_C) ? ST_C : is_s ? ST_D : ST_E;
    endcase
  endfunction

  function automatic logic [65:0] encode(logic [63:0] d, int kind, int tk, logic [7:0] em);
    logic [7:0]  types [8];
    logic [63:0] blk;
    types = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
    case (kind)
      K_D:  return {2'b01, d};
      K_C:  return {2'b10, ctrl_block(em)};
      K_S0: return {2'b10, d[63:8], 8'h78};
      K_S4: return {2'b10, d[63:40], 32'h0, 8'h33};
      K_T: begin
        blk = '0;
        blk[7:0] = types[tk];
        for (int j = 0; j < tk; j++) blk[8*(j+1) +: 8] = d[8*j +: 8];
        return {2'b10, blk};
      end
      default: return {2'b10, ctrl_block(8'hff)};
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mstate[m] = ST_INIT;
      mvalid[m] = 1'b0;
      mhead[m]  = 2'b10;
      mdata[m]  = ctrl_block(8'hff);
    end
  endtask

  task automatic model_step(int m, bit is40);
    int kind, tk, ns;
    logic [7:0] em;
    logic [65:0] blk;
    if (!valid_i) begin
      mvalid[m] = 1'b0;
      return;
    end
    kind = classify(txd, txc, is40, tk, em);
    ns = next_state(mstate[m], kind);
    blk = (ns == ST_E) ? {2'b10, ctrl_block(8'hff)} : encode(txd, kind, tk, em);
    mstate[m] = ns;
    mvalid[m] = 1'b1;
    mhead[m]  = blk[65:64];
    mdata[m]  = blk[63:0];
  endtask

  task automatic compare(string tag);
    check_eq({tag, "_valid40"}, 64'(vo40), 64'(mvalid[0]));
    check_eq({tag, "_head40"},  64'(ho40), 64'(mhead[0]));
    check_eq({tag, "_data40"},  do40,      mdata[0]);
    check_eq({tag, "_valid10"}, 64'(vo10), 64'(mvalid[1]));
    check_eq({tag, "_head10"},  64'(ho10), 64'(mhead[1]));
    check_eq({tag, "_data10"},  do10,      mdata[1]);
  endtask

  // ---------------- stimulus ----------------
  task automatic send(string tag, bit v, logic [7:0] c, logic [63:0] d);
    @(negedge clk);
    valid_i = v;
    txc = c;
    txd = d;
    @(posedge clk);
    #1;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    compare(tag);
  endtask

  task automatic apply_reset(string tag);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    compare(tag);
    @(negedge clk);
    valid_i = 1'b0;
    nreset = 1'b1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;

  task automatic send_idle(string tag);
    send(tag, 1'b1, 8'hff, IDLE_D);
  endtask

  task automatic send_start(string tag);
    logic [63:0] d;
    d = rand64();
    d[7:0] = 8'hfb;
    send(tag, 1'b1, 8'h01, d);
  endtask

  task automatic send_start4(string tag);
    logic [63:0] d;
    d = rand64();
    d[39:0] = 40'hfb07070707;
    send(tag, 1'b1, 8'h1f, d);
  endtask

  task automatic send_data(string tag);
    send(tag, 1'b1, 8'h00, rand64());
  endtask

  task automatic send_term(string tag, int k);
    logic [63:0] d;
    d = rand64();
    for (int i = k; i < 8; i++) d[8*i +: 8] = (i == k) ? 8'hfd : 8'h07;
    send(tag, 1'b1, 8'((9'h0ff << k) & 9'h0ff), d);
  endtask

  task automatic send_stall(string tag);
    send(tag, 1'b0, 8'($urandom), rand64());
  endtask

  initial begin
    logic [63:0] d;
    int r;
    model_reset();
    #2;

    // Reset state and idle stream.
    apply_reset("rst");
    for (int i = 0; i < 4; i++) begin
      send_idle("idle");
      check_eq("idle_lit", do40, 64'h000000000000001e);
    end

    // Basic frame: start, 3 data, terminate in lane 3.
    send_idle("f_idle");
    send_start("f_start");
    for (int i = 0; i < 3; i++) send_data("f_data");
    send_term("f_term3", 3);
    check_eq("term3_type", 64'(do40[7:0]), 64'h0000_0000_0000_00b4);
    send_idle("f_idle2");

    // Terminate-lane sweep.
    for (int k = 0; k < 8; k++) begin
      send_start("sw_start");
      send_data("sw_data");
      send_term("sw_term", k);
      send_idle("sw_idle");
    end

    // Illegal sequences.
    send_idle("il_idle");
    send_data("il_d_after_c");
    check_eq("il_err_lit", do40, {{8{7'h1e}}, 8'h1e});
    send_start("il_s_after_e");
    send_idle("il_recover");

    // Stall mid-frame.
    send_start("st_start");
    send_data("st_data");
    for (int i = 0; i < 5; i++) send_stall("st_hold");
    send_data("st_resume");
    send_term("st_term", 2);
    send_idle("st_idle");

    // Lane-4 start: legal only on the XGMII instance.
    send_idle("s4_idle");
    send_start4("s4_start");
    send_data("s4_data");
    send_data("s4_data2");
    send_term("s4_term", 5);
    send_idle("s4_idle2");

    // Reset mid-frame, then data straight out of init.
    send_start("mr_start");
    send_data("mr_data");
    apply_reset("mr_rst");
    send_data("mr_d_init");
    send_idle("mr_idle");
    send_start("mr_start2");
    send_term("mr_term0", 0);

    // Random mixture of legal and illegal vectors.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: send_idle("rnd_idle");
        1: begin
          d = IDLE_D;
          for (int i = 0; i < 8; i++) if ($urandom_range(0, 2) == 0) d[8*i +: 8] = 8'hfe;
          send("rnd_ierr", 1'b1, 8'hff, d);
        end
        2: send_start("rnd_start");
        3, 4, 5: send_data("rnd_data");
        6, 7: send_term("rnd_term", $urandom_range(0, 7));
        8: send_start4("rnd_start4");
        9: send_stall("rnd_stall");
        10: begin
          d = rand64();
          d[7:0] = 8'h9c;
          send("rnd_oset", 1'b1, 8'h01, d);
        end
        default: send("rnd_junk", 1'b1, 8'($urandom), rand64());
      endcase
      if (n == 700) apply_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
